// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with sync load/clear, tc and sticky wrap flag.
// Define MOD_UPDOWN_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module mod_updown_counter #(
   parameter int     WIDTH     = 4,
   parameter longint MODULUS   = 10,
   parameter longint RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrapped
);

   // One extra bit so MODULUS = 2^WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

   logic [WIDTH:0]   inc;
   logic             at_top;
   logic             at_bot;
   logic             clamp;
   logic [WIDTH-1:0] q_next;
   logic             w_next;

   assign inc    = {1'b0, q} + (WIDTH+1)'(1);
   assign at_top = (inc == MOD_W);
   assign at_bot = (q == '0);
   assign clamp  = ({1'b0, load_val} >= MOD_W);

   assign tc = enable & ~load & ~clear &
               ((up_dn & at_top) | (~up_dn & at_bot));

   always_comb begin
      q_next = q;
      w_next = wrapped;
      if (clear) begin
         q_next = '0;
         w_next = 1'b0;
      end else if (load) begin
         q_next = clamp ? TOP : load_val;
      end else if (enable) begin
         if (up_dn) begin
            if (at_top) begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
               q_next = TOP;
`else
               q_next = '0;
`endif
               w_next = 1'b1;
            end else begin
               q_next = inc[WIDTH-1:0];
            end
         end else begin
            if (at_bot) begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
               q_next = '0;
`else
               q_next = TOP;
`endif
               w_next = 1'b1;
            end else begin
               q_next = q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q       <= RST_Q;
         wrapped <= 1'b0;
      end else begin
         q       <= q_next;
         wrapped <= w_next;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: vector table, corner sequences,
// and random stimulus against a modulo-arithmetic reference model.
module tb_mod_updown_counter;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       enable;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic       clear;
   logic [3:0] q;
   logic       tc;
   logic       wrapped;
   logic [3:0] q16;
   logic       tc16;
   logic       wrapped16;

   int errors = 0;
   int checks = 0;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
      .load(load), .load_val(load_val), .clear(clear),
      .q(q), .tc(tc), .wrapped(wrapped)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) dut16 (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
      .load(load), .load_val(load_val), .clear(clear),
      .q(q16), .tc(tc16), .wrapped(wrapped16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       ld;
      logic [3:0] lv;
      logic       en;
      logic       ud;
      logic       tc;
      logic [3:0] q;
      logic       w;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic l, input logic [3:0] v,
                        input logic e, input logic u);
      clear = c; load = l; load_val = v; enable = e; up_dn = u;
   endtask

   // Reference: counting is plain modulo-M arithmetic on an int.
   function automatic void mstep(input int m, inout int mq, inout bit mw,
                                 input bit c, input bit l, input int v,
                                 input bit e, input bit u);
      int s;
      if (c) begin
         mq = 0; mw = 0;
      end else if (l) begin
         mq = (v < m) ? v : m - 1;
      end else if (e) begin
         s = u ? mq + 1 : mq - 1;
         if (s < 0 || s >= m) begin
            mw = 1;
            if (SAT) mq = (s < 0) ? 0 : m - 1;
            else     mq = (s + m) % m;
         end else begin
            mq = s;
         end
      end
   endfunction

   function automatic bit mtc(input int m, input int mq, input bit c,
                              input bit l, input bit e, input bit u);
      return e && !l && !c && (u ? (mq == m - 1) : (mq == 0));
   endfunction

   int mq10, mq16;
   bit mw10, mw16;
   int exp_q;
   int pre;

   initial begin
      reset = 1'b1;
      drive(0, 0, 4'd0, 0, 1);

      tbl[0] = '{0, 1, 4'd7,  0, 1, 0, 4'd7, 0};
      tbl[1] = '{0, 1, 4'd12, 0, 1, 0, 4'd9, 0};
      tbl[2] = '{0, 0, 4'd0,  1, 1, 1, SAT ? 4'd9 : 4'd0, 1};
      tbl[3] = '{1, 1, 4'd5,  1, 1, 0, 4'd0, 0};
      tbl[4] = '{0, 1, 4'd4,  1, 1, 0, 4'd4, 0};
      tbl[5] = '{0, 0, 4'd0,  1, 0, 0, 4'd3, 0};
      tbl[6] = '{0, 0, 4'd0,  0, 0, 0, 4'd3, 0};
      tbl[7] = '{0, 1, 4'd0,  0, 1, 0, 4'd0, 0};
      tbl[8] = '{0, 0, 4'd0,  1, 0, 1, SAT ? 4'd0 : 4'd9, 1};
      tbl[9] = '{0, 1, 4'd15, 1, 1, 0, 4'd9, 1};

      tick();
      tick();
      chk("reset_q", 32'(q), 32'd0);
      chk("reset_w", 32'(wrapped), 32'd0);
      chk("reset_q16", 32'(q16), 32'd3);
      reset = 1'b0;

      // Count to 6, then assert reset between edges
      drive(0, 0, 4'd0, 1, 1);
      repeat (6) tick();
      chk("pre_async_q", 32'(q), 32'd6);
      #2 reset = 1'b1;
      #1;
      chk("async_q", 32'(q), 32'd0);
      chk("async_w", 32'(wrapped), 32'd0);
      chk("async_q16", 32'(q16), 32'd3);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("restart_q", 32'(q), 32'd1);

      // Vector table
      drive(1, 0, 4'd0, 0, 1);
      tick();
      foreach (tbl[i]) begin
         drive(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].ud);
         #1;
         chk($sformatf("tbl%0d_tc", i), 32'(tc), 32'(tbl[i].tc));
         tick();
         chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
         chk($sformatf("tbl%0d_w", i), 32'(wrapped), 32'(tbl[i].w));
      end

      // Up count 12 edges from 0
      drive(1, 0, 4'd0, 0, 1);
      tick();
      drive(0, 0, 4'd0, 1, 1);
      for (int i = 1; i <= 12; i++) begin
         pre = SAT ? ((i - 1 > 9) ? 9 : i - 1) : (i - 1) % 10;
         #1;
         chk($sformatf("up%0d_tc", i), 32'(tc), 32'(pre == 9));
         tick();
         exp_q = SAT ? ((i > 9) ? 9 : i) : i % 10;
         chk($sformatf("up%0d_q", i), 32'(q), 32'(exp_q));
         chk($sformatf("up%0d_w", i), 32'(wrapped), 32'(i >= 10));
      end

      // Down 3 edges from 0, then hold 4 edges
      drive(1, 0, 4'd0, 0, 1);
      tick();
      drive(0, 0, 4'd0, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         pre = SAT ? 0 : ((i == 1) ? 0 : 11 - i);
         #1;
         chk($sformatf("dn%0d_tc", i), 32'(tc), 32'(pre == 0));
         tick();
         chk($sformatf("dn%0d_q", i), 32'(q), SAT ? 32'd0 : 32'(10 - i));
         chk($sformatf("dn%0d_w", i), 32'(wrapped), 32'd1);
      end
      enable = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("hold%0d_tc", i), 32'(tc), 32'd0);
         tick();
         chk($sformatf("hold%0d_q", i), 32'(q), SAT ? 32'd0 : 32'd7);
      end

      // MODULUS = 2^WIDTH corner
      drive(1, 0, 4'd0, 0, 1);
      tick();
      drive(0, 1, 4'd15, 0, 1);
      tick();
      chk("m16_load_q", 32'(q16), 32'd15);
      drive(0, 0, 4'd0, 1, 1);
      #1;
      chk("m16_tc", 32'(tc16), 32'd1);
      tick();
      chk("m16_wrap_q", 32'(q16), SAT ? 32'd15 : 32'd0);
      chk("m16_wrap_w", 32'(wrapped16), 32'd1);

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      drive(1, 0, 4'd0, 0, 1);
      tick();
      drive(0, 1, 4'd8, 0, 1);
      tick();
      drive(0, 0, 4'd0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("sat_up%0d_q", i), 32'(q), 32'd9);
         chk($sformatf("sat_up%0d_w", i), 32'(wrapped), 32'(i >= 1));
      end
      drive(0, 1, 4'd1, 0, 0);
      tick();
      drive(0, 0, 4'd0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("sat_dn%0d_q", i), 32'(q), 32'd0);
      end
`endif

      // Random stimulus against the reference model
      drive(1, 0, 4'd0, 0, 1);
      tick();
      mq10 = 0; mw10 = 0; mq16 = 0; mw16 = 0;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(15) == 0), ($urandom_range(7) == 0),
               4'($urandom_range(15)), ($urandom_range(3) != 0),
               1'($urandom_range(1)));
         #1;
         chk("rnd_tc", 32'(tc), 32'(mtc(10, mq10, clear, load, enable, up_dn)));
         chk("rnd_tc16", 32'(tc16),
             32'(mtc(16, mq16, clear, load, enable, up_dn)));
         mstep(10, mq10, mw10, clear, load, int'(load_val), enable, up_dn);
         mstep(16, mq16, mw16, clear, load, int'(load_val), enable, up_dn);
         tick();
         chk("rnd_q", 32'(q), 32'(mq10));
         chk("rnd_w", 32'(wrapped), 32'(mw10));
         chk("rnd_q16", 32'(q16), 32'(mq16));
         chk("rnd_w16", 32'(wrapped16), 32'(mw16));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
